// File: rtl/ann_pkg.sv
// Shared constants and FSM encoding for the ANN layer weight-fetch logic.
package ann_pkg;

  localparam int unsigned ANN_DATA_W = 16;
  localparam int unsigned ANN_ADDR_W = 5;
  localparam int unsigned ANN_WDEPTH = 28;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } wfetch_state_e;

endpackage

// File: rtl/wfetch_skid_fifo.sv
// Two-entry in-order FIFO that absorbs BRAM reads while the MAC stalls.
module wfetch_skid_fifo #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;
  logic             wr_ptr;

  assign do_pop = pop && (count_q != 2'd0);
  // With push and pop at count 2 the write lands in the slot being vacated.
  assign wr_ptr = rd_ptr_q ^ count_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= push_data;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams DEPTH words out of a negedge-read weight BRAM as a valid/ready stream.
// Define WFETCH_LAST_EN to add the W_LAST end-of-run marker port.
module weight_fetch_ctrl
  import ann_pkg::*;
#(
  parameter int unsigned DATA_W = ANN_DATA_W,
  parameter int unsigned ADDR_W = ANN_ADDR_W,
  parameter int unsigned DEPTH  = ANN_WDEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  output logic              WE,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] DO_IN,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
`ifdef WFETCH_LAST_EN
  output logic              W_LAST,
`endif
  input  logic              W_READY
);

`ifdef WFETCH_LAST_EN
  localparam int unsigned FifoW = DATA_W + 1;
`else
  localparam int unsigned FifoW = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  wfetch_state_e     state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic              issue;
  logic              pop;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [FifoW-1:0]  push_data;
  logic [FifoW-1:0]  head;

  assign pop = fifo_valid & W_READY;
  // Issue only if the buffer, after this edge's capture/pop, can still take the new read.
  assign issue = (state_q == StRun) &&
                 ((3'(fifo_count) + 3'(en_q) - 3'(pop)) < 3'd2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = StRun;
      StRun:   if (issue && (next_addr_q == LastAddr)) state_d = StDrain;
      StDrain: if (DONE) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    BUSY = (state_q != StIdle);
    DONE = (state_q == StDrain) && !en_q && (fifo_count == 2'd1) && pop;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q        <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
    end else begin
      en_q <= issue;
      if (issue) begin
        addr_q      <= next_addr_q;
        next_addr_q <= next_addr_q + ADDR_W'(1);
      end else if (state_q == StIdle) begin
        next_addr_q <= '0;
      end
    end
  end

`ifdef WFETCH_LAST_EN
  assign push_data = {(addr_q == LastAddr), DO_IN};
  assign W_LAST    = fifo_valid & head[DATA_W];
`else
  assign push_data = DO_IN;
`endif

  wfetch_skid_fifo #(
    .WIDTH(FifoW)
  ) u_skid (
    .clk      (CLK),
    .rst      (RST),
    .push     (en_q),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign ADDR    = addr_q;
  assign EN      = en_q;
  assign WE      = 1'b0;
  assign DI      = '0;
  assign W_DATA  = head[DATA_W-1:0];
  assign W_VALID = fifo_valid;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: BRAM model, word-order reference and DEPTH=1 instance.
// Build with WFETCH_LAST_EN defined to also check W_LAST.
module tb_weight_fetch_ctrl;

  localparam int unsigned DEPTH = 28;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, en, we, w_valid, w_ready;
  logic [4:0]  addr;
  logic [15:0] di, do_in, w_data;
  logic        w_last;
  logic        start1, busy1, done1, en1, we1, w_valid1, w_ready1;
  logic [4:0]  addr1;
  logic [15:0] di1, do_in1, w_data1;
  logic        w_last1;

  logic [15:0] bram [32];

  int n_vec;
  int n_err;
  int idx;
  int issued;
  int done_pulses;
  bit prev_stall;
  logic [15:0] prev_data;
  bit pat [4];

  weight_fetch_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(DEPTH)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done), .ADDR(addr), .EN(en),
    .WE(we), .DI(di), .DO_IN(do_in), .W_DATA(w_data), .W_VALID(w_valid),
`ifdef WFETCH_LAST_EN
    .W_LAST(w_last),
`endif
    .W_READY(w_ready)
  );

  weight_fetch_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(1)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .BUSY(busy1), .DONE(done1), .ADDR(addr1),
    .EN(en1), .WE(we1), .DI(di1), .DO_IN(do_in1), .W_DATA(w_data1), .W_VALID(w_valid1),
`ifdef WFETCH_LAST_EN
    .W_LAST(w_last1),
`endif
    .W_READY(w_ready1)
  );

`ifndef WFETCH_LAST_EN
  assign w_last  = 1'b0;
  assign w_last1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) bram[i] = 16'h0100 + 16'(i);
    do_in  = 16'h0;
    do_in1 = 16'h0;
  end

  // Negedge-read BRAMs.
  always @(negedge clk) if (en) do_in <= bram[addr];
  always @(negedge clk) if (en1) do_in1 <= bram[addr1];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: word k of a run is 0x0100+k, one transfer per valid&ready, DONE on the last.
  task automatic sample();
    bit xfer;
    if (rst) begin
      idx = 0;
      issued = 0;
      prev_stall = 0;
      return;
    end
    if (en) begin
      check_eq("en_occupancy_lt2", (issued - idx) <= 1, 1);
      check_eq("en_addr_order", addr, issued);
      issued++;
    end
    if (prev_stall) begin
      check_eq("hold_valid", w_valid, 1);
      check_eq("hold_data", w_data, prev_data);
    end
`ifdef WFETCH_LAST_EN
    if (w_valid) check_eq("w_last", w_last, w_data == 16'h0100 + 16'(DEPTH - 1));
`endif
    xfer = w_valid && w_ready;
    check_eq("done", done, xfer && (idx == DEPTH - 1));
    if (done) done_pulses++;
    if (xfer) begin
      check_eq("w_data", w_data, 16'h0100 + 16'(idx));
      idx++;
    end
    prev_stall = w_valid && !w_ready;
    prev_data  = w_data;
    if (idx == DEPTH) begin
      idx = 0;
      issued = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready and random START noise.
  task automatic run_words(input int mode, input bit mid_start, output int lat);
    bit fired;
    int pulses0;
    lat = -1;
    fired = 0;
    pulses0 = done_pulses;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 600; c++) begin
      start = 1'b0;
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = pat[(c - 1) % 4];
        default: w_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mid_start && !fired && idx == 10) begin
        start = 1'b1;
        fired = 1;
      end
      if (mode == 2 && $urandom_range(0, 7) == 0) start = 1'b1;
      @(negedge clk);
      sample();
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    w_ready = 1'b0;
    check_eq("run_completed", lat != -1, 1);
    @(negedge clk);
    sample();
    check_eq("busy_after_done", busy, 0);
    check_eq("single_done_pulse", done_pulses - pulses0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int pulses0;
    n_vec = 0;
    n_err = 0;
    idx = 0;
    issued = 0;
    done_pulses = 0;
    prev_stall = 0;
    prev_data = '0;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    w_ready = 1'b0;
    w_ready1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_en", en, 0);
    check_eq("rst_we", we, 0);
    check_eq("rst_di", di, 0);
    check_eq("rst_w_valid", w_valid, 0);
    check_eq("rst_w_data", w_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Full-rate run: DEPTH+2 cycles START->DONE.
    run_words(0, 0, lat);
    check_eq("latency_full_rate", lat, DEPTH + 2);

    run_words(1, 0, lat);

    // START mid-run is ignored; the next START runs from address 0.
    run_words(0, 1, lat);
    check_eq("latency_mid_start", lat, DEPTH + 2);
    run_words(0, 0, lat);
    check_eq("latency_restart", lat, DEPTH + 2);

    // Abort with reset while the MAC stalls.
    pulses0 = done_pulses;
    w_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 100 && idx < 15; c++) step();
    check_eq("reached_word15", idx, 15);
    w_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    sample();
    check_eq("abort_w_valid", w_valid, 0);
    check_eq("abort_en", en, 0);
    check_eq("abort_addr", addr, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_no_done_pulse", done_pulses - pulses0, 0);
    @(posedge clk);
    #1;
    run_words(0, 0, lat);
    check_eq("latency_after_abort", lat, DEPTH + 2);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 3)) step();
      run_words(2, 0, lat);
      check_eq("latency_lower_bound", lat >= DEPTH + 2, 1);
    end

    // DEPTH=1 instance: EN in cycle 2, single word and DONE in cycle 3.
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      sample();
      check_eq("d1_en", en1, c == 2);
      check_eq("d1_w_valid", w_valid1, c == 3);
      check_eq("d1_done", done1, c == 3);
      check_eq("d1_busy", busy1, c <= 3);
      if (c == 2) check_eq("d1_addr", addr1, 0);
      if (c == 3) check_eq("d1_w_data", w_data1, 16'h0100);
`ifdef WFETCH_LAST_EN
      if (c == 3) check_eq("d1_w_last", w_last1, 1);
`endif
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
